evt_readout_scheduler: RTL and testbench



---
 rtl/evt_readout_scheduler_pkg.sv | 14 +
 rtl/evt_readout_scheduler_ch_priority_sel.sv | 15 +
 rtl/evt_readout_scheduler.sv | 136 +++++++++++++
 tb/tb_evt_readout_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/evt_readout_scheduler_pkg.sv
// evt_readout_scheduler_pkg: shared constants and state encoding for the event readout scheduler
package evt_readout_scheduler_pkg;
  localparam int NUM_CH = 16;
  localparam logic [15:0] HDR_WORD = 16'hA5A5;
  localparam logic [15:0] TRL_WORD = 16'h5A5A;
  localparam logic [15:0] PAD_WORD = 16'hDEAD;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR = 3'd1;
  localparam logic [2:0] S_CH_SEL = 3'd2;
  localparam logic [2:0] S_READ = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_GAP = 3'd6;
endpackage

// File: rtl/evt_readout_scheduler_ch_priority_sel.sv
// evt_readout_scheduler_ch_priority_sel: lowest enabled channel index at or above ch_ptr
module evt_readout_scheduler_ch_priority_sel import evt_readout_scheduler_pkg::*; (
  input  logic [NUM_CH-1:0] mask,
  input  logic [4:0]        ch_ptr,
  output logic [3:0]        idx,
  output logic              valid
);
  logic [NUM_CH-1:0] cand;
  always_comb begin
    cand = mask & ({NUM_CH{1'b1}} << ch_ptr);
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (cand[i]) idx = 4'(i);
    valid = |cand;
  end
endmodule

// File: rtl/evt_readout_scheduler.sv
// evt_readout_scheduler: reads one event from the enabled channel FIFOs and frames it for the SFP transmit path
module evt_readout_scheduler import evt_readout_scheduler_pkg::*; #(
  parameter int          EVT_WORDS  = 8,
  parameter logic [15:0] HDR_WORD   = evt_readout_scheduler_pkg::HDR_WORD,
  parameter logic [15:0] TRL_WORD   = evt_readout_scheduler_pkg::TRL_WORD,
  parameter int          GAP_CYCLES = 4,
  parameter int          TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         need_read,
  input  logic [15:0]  ch_mask,
  input  logic [255:0] fifo_dout,
  input  logic [15:0]  fifo_empty,
  output logic [15:0]  fifo_rd_en,
  input  logic         tx_ready,
  output logic [15:0]  tx_data,
  output logic         tx_valid,
  output logic         tx_sof,
  output logic         tx_eof,
  output logic [15:0]  evt_tx,
  output logic         busy,
  output logic         err_timeout,
  output logic [3:0]   err_ch
);
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [2:0] state;
  logic [15:0] mask_q;
  logic [4:0] ch_ptr;
  logic [3:0] ch, sel_idx;
  logic sel_valid, hdr_done, pend, pad, more, strobe;
  logic [7:0] issued, gap_cnt;
  logic [SW-1:0] stall;
  evt_readout_scheduler_ch_priority_sel u_sel (
    .mask(mask_q), .ch_ptr(ch_ptr), .idx(sel_idx), .valid(sel_valid)
  );
  assign more = issued < 8'(EVT_WORDS);
  assign strobe = state == S_READ && !pad && tx_ready && !fifo_empty[ch] && more;
  // pend marks the cycle the FIFO presents data for last cycle's strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      mask_q <= '0;
      ch_ptr <= '0;
      ch <= '0;
      hdr_done <= 1'b0;
      pend <= 1'b0;
      pad <= 1'b0;
      issued <= '0;
      gap_cnt <= '0;
      stall <= '0;
      fifo_rd_en <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      tx_sof <= 1'b0;
      tx_eof <= 1'b0;
      evt_tx <= '0;
      busy <= 1'b0;
      err_timeout <= 1'b0;
      err_ch <= '0;
    end else begin
      fifo_rd_en <= strobe ? 16'(1) << ch : '0;
      pend <= |fifo_rd_en;
      tx_valid <= 1'b0;
      tx_sof <= 1'b0;
      tx_eof <= 1'b0;
      if (pend) begin
        tx_data <= fifo_dout[16*ch +: 16];
        tx_valid <= 1'b1;
      end
      case (state)
        S_IDLE: if (need_read && tx_ready) begin
          state <= S_HDR;
          mask_q <= ch_mask;
          hdr_done <= 1'b0;
          busy <= 1'b1;
        end
        S_HDR: if (tx_ready) begin
          tx_data <= hdr_done ? evt_tx : HDR_WORD;
          tx_valid <= 1'b1;
          tx_sof <= !hdr_done;
          hdr_done <= 1'b1;
          if (hdr_done) begin
            state <= S_CH_SEL;
            ch_ptr <= '0;
          end
        end
        S_CH_SEL: begin
          ch <= sel_idx;
          issued <= '0;
          stall <= '0;
          pad <= 1'b0;
          state <= sel_valid ? S_READ : S_TRAIL;
        end
        S_READ: begin
          if (strobe) begin
            issued <= issued + 8'd1;
            stall <= '0;
          end else if (pad) begin
            if (tx_ready && more && !pend && fifo_rd_en == '0) begin
              tx_data <= PAD_WORD;
              tx_valid <= 1'b1;
              issued <= issued + 8'd1;
            end
          end else if (fifo_empty[ch] && more) begin
            if (stall == SW'(TIMEOUT - 1)) begin
              pad <= 1'b1;
              err_timeout <= 1'b1;
              err_ch <= ch;
            end else stall <= stall + SW'(1);
          end
          if (!more && !pend && fifo_rd_en == '0) begin
            state <= S_CH_SEL;
            ch_ptr <= 5'(ch) + 5'd1;
          end
        end
        S_TRAIL: if (tx_ready) begin
          tx_data <= TRL_WORD;
          tx_valid <= 1'b1;
          tx_eof <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          evt_tx <= evt_tx + 16'd1;
          gap_cnt <= '0;
          state <= S_GAP;
        end
        S_GAP: if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
          state <= S_IDLE;
          busy <= 1'b0;
        end else gap_cnt <= gap_cnt + 8'd1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_evt_readout_scheduler.sv
// tb_evt_readout_scheduler: FIFO model plus word scoreboard around the event readout scheduler
module tb_evt_readout_scheduler;
  localparam int EW = 8;
  logic clk = 1'b0, reset = 1'b0, need_read = 1'b0, rdy_base = 1'b0, tog_en = 1'b0, flush = 1'b0;
  logic [15:0] ch_mask = '0, stuck = '0, fifo_empty, fifo_rd_en, tx_data, evt_tx;
  logic [255:0] fifo_dout = '0;
  logic tx_ready, tx_valid, tx_sof, tx_eof, busy, err_timeout;
  logic [3:0] err_ch;
  logic [15:0] mem [16][64];
  logic [5:0] wp [16] = '{default: '0};
  logic [5:0] rp [16] = '{default: '0};
  logic [2:0] tcnt = '0;
  logic [17:0] exp_q [$];
  logic [17:0] got, e;
  logic [15:0] exp_evt = '0;
  int n_cmp = 0, n_err = 0, words = 0;
  int rd_tot [16] = '{default: 0};

  evt_readout_scheduler #(.EVT_WORDS(EW), .GAP_CYCLES(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .need_read(need_read), .ch_mask(ch_mask),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_sof(tx_sof),
    .tx_eof(tx_eof), .evt_tx(evt_tx), .busy(busy), .err_timeout(err_timeout), .err_ch(err_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= (tcnt == 3'd5) ? 3'd0 : tcnt + 3'd1;
  assign tx_ready = rdy_base & ~(tog_en & (tcnt >= 3'd3));

  always_comb for (int n = 0; n < 16; n++) fifo_empty[n] = (wp[n] == rp[n]) | stuck[n];
  always @(posedge clk)
    for (int n = 0; n < 16; n++)
      if (flush) rp[n] <= wp[n];
      else if (fifo_rd_en[n]) begin
        fifo_dout[16*n +: 16] <= mem[n][rp[n]];
        rp[n] <= rp[n] + 6'd1;
      end

  always @(negedge clk) if (!reset) begin
    for (int n = 0; n < 16; n++) rd_tot[n] += int'(fifo_rd_en[n]);
    if (|fifo_rd_en) begin
      n_cmp++;
      if (!$onehot(fifo_rd_en)) begin n_err++; $display("FAIL rd_en_onehot got %h", fifo_rd_en); end
    end
    if (tx_valid) begin
      words++;
      n_cmp++;
      got = {tx_sof, tx_eof, tx_data};
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL word_%0d got %h expected none", words, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL word_%0d got sof/eof/data %h expected %h", words, got, e); end
      end
    end
  end

  function automatic logic [15:0] dword(int n, int tag, int k);
    return {4'(n), 4'(tag), 8'(k)};
  endfunction

  task automatic fill(input logic [15:0] mask, input int tag);
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    for (int n = 0; n < 16; n++)
      if (mask[n]) for (int k = 0; k < EW; k++) begin
        mem[n][wp[n]] = dword(n, tag, k);
        wp[n] = wp[n] + 6'd1;
      end
  endtask

  task automatic push_frame(input logic [15:0] mask, input logic [15:0] padm, input int tag);
    exp_q.push_back({2'b10, 16'hA5A5});
    exp_q.push_back({2'b00, exp_evt});
    for (int n = 0; n < 16; n++)
      if (mask[n]) for (int k = 0; k < EW; k++) exp_q.push_back({2'b00, padm[n] ? 16'hDEAD : dword(n, tag, k)});
    exp_q.push_back({2'b01, 16'h5A5A});
  endtask

  task automatic run_frame(input logic [15:0] mask, output bit ok);
    ch_mask = mask; need_read = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    need_read = 1'b0; ch_mask = ~mask;
    if (busy) for (int i = 0; i < 4000 && !ok; i++) begin @(negedge clk); ok = !busy; end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_valid, tx_sof, tx_eof, tx_data, fifo_rd_en, busy} !== '0) begin
      n_err++; $display("FAIL reset_outputs got v=%b sof=%b eof=%b d=%h rd=%h busy=%b expected 0", tx_valid, tx_sof, tx_eof, tx_data, fifo_rd_en, busy);
    end
    n_cmp++;
    if ({evt_tx, err_timeout, err_ch} !== '0) begin
      n_err++; $display("FAIL reset_counters got evt=%h err=%b ch=%0d expected 0", evt_tx, err_timeout, err_ch);
    end
    reset = 1'b0; rdy_base = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_mask;
    int w0; int r0 [16]; bit ok;
    fill(16'hFFFF, 1); push_frame(16'hFFFF, '0, 1);
    w0 = words; r0 = rd_tot;
    run_frame(16'hFFFF, ok); exp_evt++;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL full_done got busy=%b expected idle", busy); end
    n_cmp++; if (words - w0 !== 131) begin n_err++; $display("FAIL full_len got %0d expected 131", words - w0); end
    n_cmp++; if (evt_tx !== exp_evt) begin n_err++; $display("FAIL full_evt got %h expected %h", evt_tx, exp_evt); end
    for (int n = 0; n < 16; n++) begin
      n_cmp++;
      if (rd_tot[n] - r0[n] !== EW) begin n_err++; $display("FAIL full_rd_ch%0d got %0d expected %0d", n, rd_tot[n] - r0[n], EW); end
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL full_left got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_sparse_mask;
    int w0; int r0 [16]; bit ok;
    fill(16'h8001, 2); push_frame(16'h8001, '0, 2);
    w0 = words; r0 = rd_tot;
    run_frame(16'h8001, ok); exp_evt++;
    n_cmp++; if (words - w0 !== 19) begin n_err++; $display("FAIL sparse_len got %0d expected 19", words - w0); end
    n_cmp++; if (evt_tx !== exp_evt) begin n_err++; $display("FAIL sparse_evt got %h expected %h", evt_tx, exp_evt); end
    for (int n = 0; n < 16; n++) begin
      n_cmp++;
      if (rd_tot[n] - r0[n] !== ((n == 0 || n == 15) ? EW : 0)) begin
        n_err++; $display("FAIL sparse_rd_ch%0d got %0d", n, rd_tot[n] - r0[n]);
      end
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL sparse_left got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_ready_toggle;
    int w0; bit ok;
    fill(16'hFFFF, 3); push_frame(16'hFFFF, '0, 3);
    w0 = words; tog_en = 1'b1;
    run_frame(16'hFFFF, ok); exp_evt++; tog_en = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL toggle_done got busy=%b expected idle", busy); end
    n_cmp++; if (words - w0 !== 131) begin n_err++; $display("FAIL toggle_len got %0d expected 131", words - w0); end
    n_cmp++; if (evt_tx !== exp_evt) begin n_err++; $display("FAIL toggle_evt got %h expected %h", evt_tx, exp_evt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL toggle_left got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout;
    int w0; int r0 [16]; bit ok;
    stuck = 16'h0020;
    fill(16'hFFDF, 4); push_frame(16'hFFFF, 16'h0020, 4);
    w0 = words; r0 = rd_tot;
    run_frame(16'hFFFF, ok); exp_evt++; stuck = '0;
    n_cmp++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL to_flag got %b expected 1", err_timeout); end
    n_cmp++; if (err_ch !== 4'd5) begin n_err++; $display("FAIL to_ch got %0d expected 5", err_ch); end
    n_cmp++; if (words - w0 !== 131) begin n_err++; $display("FAIL to_len got %0d expected 131", words - w0); end
    n_cmp++; if (rd_tot[5] - r0[5] !== 0) begin n_err++; $display("FAIL to_rd_ch5 got %0d expected 0", rd_tot[5] - r0[5]); end
    n_cmp++; if (evt_tx !== exp_evt) begin n_err++; $display("FAIL to_evt got %h expected %h", evt_tx, exp_evt); end
  endtask

  task automatic test_wrap;
    int w0; bit ok;
    force dut.evt_tx = 16'hFFFF;
    @(negedge clk); release dut.evt_tx; @(negedge clk);
    n_cmp++; if (evt_tx !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload got %h expected ffff", evt_tx); end
    exp_evt = 16'hFFFF; w0 = words;
    push_frame('0, '0, 0); run_frame('0, ok); exp_evt++;
    n_cmp++; if (evt_tx !== 16'h0000) begin n_err++; $display("FAIL wrap_evt got %h expected 0000", evt_tx); end
    push_frame('0, '0, 0); run_frame('0, ok); exp_evt++;
    n_cmp++; if (evt_tx !== 16'h0001) begin n_err++; $display("FAIL wrap_next got %h expected 0001", evt_tx); end
    n_cmp++; if (words - w0 !== 6) begin n_err++; $display("FAIL wrap_len got %0d expected 6", words - w0); end
  endtask

  task automatic test_reset_mid_read;
    int w0; bit ok;
    fill(16'hFFFF, 6); push_frame(16'hFFFF, '0, 6);
    ch_mask = 16'hFFFF; need_read = 1'b1; ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = fifo_rd_en[7]; end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_reach_ch7 got rd=%h expected ch7 strobe", fifo_rd_en); end
    #2 reset = 1'b1; #1;
    n_cmp++;
    if ({tx_valid, tx_sof, tx_eof, tx_data, fifo_rd_en, busy, err_timeout} !== '0) begin
      n_err++; $display("FAIL mid_outputs got v=%b eof=%b d=%h rd=%h busy=%b err=%b expected 0", tx_valid, tx_eof, tx_data, fifo_rd_en, busy, err_timeout);
    end
    n_cmp++; if (evt_tx !== 16'h0000) begin n_err++; $display("FAIL mid_evt got %h expected 0000", evt_tx); end
    exp_q.delete(); exp_evt = '0;
    fill(16'hFFFF, 7); push_frame(16'hFFFF, '0, 7);
    @(negedge clk); reset = 1'b0; w0 = words;
    run_frame(16'hFFFF, ok); exp_evt++;
    n_cmp++; if (words - w0 !== 131) begin n_err++; $display("FAIL mid_len got %0d expected 131", words - w0); end
    n_cmp++; if (evt_tx !== exp_evt) begin n_err++; $display("FAIL mid_restart_evt got %h expected %h", evt_tx, exp_evt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL mid_left got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_ready_toggle();
    test_timeout();
    test_wrap();
    test_reset_mid_read();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
